axon_slide_fifo: RTL
====================

Name: axon_slide_fifo

Overview:
Next-generation axon front end for a convolutional node. Input packets are buffered in a FIFO instead of stalling the router with a busy flag. Each SPIKE packet is expanded into the set of (output-neuron, weight) pairs covered by its receptive field, with independent x/y strides. Results go out on a valid/ready stream to the synapse-dendrite (sd) stage. DATA bursts are written to soma memory.

Parameters:
- NNW, 12: neuron/coordinate arithmetic width.
- SW, 24: packet data width. Holds x, y, z fields of SW/3 bits each, z in the MSBs.
- FTW, 3: packet type width.
- FAW, 3: FIFO address width. Depth is 2^FAW entries of {type, data}.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- spk_in_vld, in, 1: input packet valid.
- spk_in_rdy, out, 1: FIFO can accept a packet (= !full).
- spk_in_data, in, SW: packet payload.
- spk_in_type, in, FTW: packet type. SPIKE=000, DATA=001, DATA_END=010; all others are dropped.
- axon_sd_vld, out, 1: sd beat valid.
- axon_sd_rdy, in, 1: sd stage accepts the beat.
- axon_sd_last, out, 1: final beat of the current spike.
- axon_sd_vm_addr, out, NNW: output neuron address.
- axon_sd_wgt_addr, out, NNW: weight address.
- axon_soma_we, out, 1: soma write strobe.
- axon_soma_waddr, out, NNW: soma write address.
- axon_soma_wdata, out, SW: soma write data.
- fifo_cnt, out, FAW+1: number of FIFO entries.
- x_in, y_in, x_k, y_k, xk_yk, x_out, pad, in, NNW each: layer geometry.
- x_start, y_start, in, SW/3 each: tile origin.
- stride_log_x, stride_log_y, in, NNW each: log2 of the stride per axis. Only values 0..4 are legal.

Behaviour:
- Reset: FIFO empty, fifo_cnt=0, spk_in_rdy=1, every other output 0, FSM in IDLE.
- Reset mid-operation discards the FIFO contents and any beats in flight.
- FIFO push: occurs on spk_in_vld & spk_in_rdy.
- FIFO pop: occurs only in IDLE, or in INPUT when non-empty.
- Push and pop in the same cycle leave fifo_cnt unchanged. A push is not accepted while full, even if a pop happens that cycle.
- Config ports must be held stable while the FSM is not in IDLE.
- FSM states: IDLE, CALC, SLIDE, INPUT.
- IDLE, FIFO non-empty, head type:
  - SPIKE: pop into command regs, go to CALC.
  - DATA: pop, go to INPUT, set we=1, waddr=0, wdata=payload.
  - Any other type: pop and drop, stay in IDLE, we=0.
- CALC (one cycle), per axis with p = coord + pad and stride s = 1<<stride_log:
  - l_start = ceil(max(0, p-k+1)/s).
  - l_end = min(floor(p/s), floor((in+2*pad-k)/s)).
  - Evaluate the max(0, ·) comparison before subtracting, so there is no underflow.
  - If l_start > l_end on either axis, the spike is ignored: go to IDLE with no beats. Otherwise latch xl=xl_start, yl=yl_start, zs, and go to SLIDE.
- SLIDE: axon_sd_vld=1. Outputs are combinational from the registers, truncated to NNW:
  - xw = px - xl*sx, yw = py - yl*sy.
  - wgt_addr = yw*x_k + xw + zs*xk_yk.
  - vm_addr = (yl - y_start)*x_out + (xl - x_start).
  - last = (xl==xl_end) & (yl==yl_end).
- SLIDE beat order: x fastest, then y. Advance only on vld & rdy. With rdy low, all sd outputs hold stable. The handshake on the last beat returns the FSM to IDLE.
- Latency: a spike pushed into an empty FIFO at edge E (FSM idle) is popped at E+1 and enters SLIDE at E+2. The first beat is valid in the cycle after E+2. With rdy held high, a W×H window takes W*H cycles.
- INPUT: each popped DATA or DATA_END produces we=1, waddr=previous+1, wdata=payload one cycle after the pop.
  - DATA_END also returns the FSM to IDLE.
  - Other popped types are dropped with we=0.
  - An empty FIFO gives we=0 and the FSM stays in INPUT.
- axon_soma_we is a single-cycle pulse per write and is 0 in all other states.

Test Plan:
1. x_in=y_in=4, x_k=y_k=3, xk_yk=9, pad=0, strides 0, x_out=2, starts 0; spike (1,1,0) -> 4 beats: vm 0,1,2,3 with wgt 4,3,1,0. Last asserted on the 4th beat; first vld 3 cycles after the push.
2. Same config, axon_sd_rdy low for 5 cycles mid-burst -> vm/wgt/last stable throughout, no beat skipped or duplicated, total still 4 beats.
3. x_k=y_k=2, stride_log_x=1, stride_log_y=0, x_in=y_in=4, spike (1,1,0) -> 2 beats with xl=0 (xw=1), yl=0 then 1 (yw=1, 0). Then x_k=1, stride_log_x=1, xs=1 -> ignored, zero beats, next FIFO entry serviced.
4. sd_rdy=0, push 10 spikes back-to-back -> one spike in service, spk_in_rdy=0 once fifo_cnt=8. Releasing rdy drains all 9 accepted spikes in order.
5. DATA 0x11, WRITE 0x99, DATA 0x22, DATA_END 0x33 -> we pulses at waddr 0,1,2 with wdata 0x11, 0x22, 0x33; WRITE dropped; FSM back in IDLE.
6. rst_n low during SLIDE with 3 entries queued -> fifo_cnt=0, spk_in_rdy=1, all outputs 0. After release, a new spike is processed normally.

Source files
------------

// File: rtl/axon_slide_fifo.sv
// axon_slide_fifo: FIFO-buffered axon front end for a convolutional node.
// Queued SPIKE packets are expanded into (output neuron, weight) beats over
// their receptive field on a valid/ready stream. DATA bursts become soma writes.
module axon_slide_fifo #(
  parameter int unsigned NNW = 12,
  parameter int unsigned SW  = 24,
  parameter int unsigned FTW = 3,
  parameter int unsigned FAW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spk_in_vld,
  output logic              spk_in_rdy,
  input  logic [SW-1:0]     spk_in_data,
  input  logic [FTW-1:0]    spk_in_type,
  output logic              axon_sd_vld,
  input  logic              axon_sd_rdy,
  output logic              axon_sd_last,
  output logic [NNW-1:0]    axon_sd_vm_addr,
  output logic [NNW-1:0]    axon_sd_wgt_addr,
  output logic              axon_soma_we,
  output logic [NNW-1:0]    axon_soma_waddr,
  output logic [SW-1:0]     axon_soma_wdata,
  output logic [FAW:0]      fifo_cnt,
  input  logic [NNW-1:0]    x_in,
  input  logic [NNW-1:0]    y_in,
  input  logic [NNW-1:0]    x_k,
  input  logic [NNW-1:0]    y_k,
  input  logic [NNW-1:0]    xk_yk,
  input  logic [NNW-1:0]    x_out,
  input  logic [NNW-1:0]    pad,
  input  logic [SW/3-1:0]   x_start,
  input  logic [SW/3-1:0]   y_start,
  input  logic [NNW-1:0]    stride_log_x,
  input  logic [NNW-1:0]    stride_log_y
);

  localparam int unsigned CW    = SW / 3;
  localparam int unsigned Depth = 1 << FAW;
  localparam int unsigned EW    = FTW + SW;

  localparam logic [FTW-1:0] TySpike   = FTW'(0);
  localparam logic [FTW-1:0] TyData    = FTW'(1);
  localparam logic [FTW-1:0] TyDataEnd = FTW'(2);

  typedef enum logic [1:0] {StIdle, StCalc, StSlide, StInput} state_e;

  // First output-window index covering padded coordinate p. The p >= k test
  // stands in for max(0, p-k+1) so the subtraction never wraps.
  function automatic logic [NNW-1:0] win_start(input logic [NNW-1:0] p,
                                               input logic [NNW-1:0] k,
                                               input logic [NNW-1:0] sl);
    logic [NNW-1:0] num;
    logic [NNW-1:0] round;
    round = (NNW'(1) << sl) - NNW'(1);
    num   = (p >= k) ? (p - k + NNW'(1)) : '0;
    return (num + round) >> sl;
  endfunction

  // Last output-window index covering p, clipped to the layer's output extent.
  function automatic logic [NNW-1:0] win_end(input logic [NNW-1:0] p,
                                             input logic [NNW-1:0] in_sz,
                                             input logic [NNW-1:0] pd,
                                             input logic [NNW-1:0] k,
                                             input logic [NNW-1:0] sl);
    logic [NNW-1:0] a;
    logic [NNW-1:0] b;
    a = p >> sl;
    b = (in_sz + (pd << 1) - k) >> sl;
    return (a < b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]  mem_q [Depth];
  logic [FAW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FAW:0]   cnt_q;
  logic           full, empty, push, pop;
  logic [FTW-1:0] head_type;
  logic [SW-1:0]  head_data;

  // Depth is a power of two, so the count MSB alone flags full.
  assign full      = cnt_q[FAW];
  assign empty     = (cnt_q == '0);
  assign push      = spk_in_vld & ~full;
  assign head_type = mem_q[rd_ptr_q][EW-1:SW];
  assign head_data = mem_q[rd_ptr_q][SW-1:0];

  // Storage array; pointers and count carry the reset state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {spk_in_type, spk_in_data};
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command, window and soma registers
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [CW-1:0]  cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d, cmd_z_q, cmd_z_d;
  logic [NNW-1:0] px_q, px_d, py_q, py_d;
  logic [NNW-1:0] xl_q, xl_d, yl_q, yl_d;
  logic [NNW-1:0] xl_start_q, xl_start_d, xl_end_q, xl_end_d, yl_end_q, yl_end_d;
  logic [NNW-1:0] zs_q, zs_d;
  logic           we_q, we_d;
  logic [NNW-1:0] waddr_q, waddr_d;
  logic [SW-1:0]  wdata_q, wdata_d;

  // Window bounds computed from the popped command during CALC.
  logic [NNW-1:0] px_c, py_c, xs_c, xe_c, ys_c, ye_c;
  logic           win_empty;

  // Receptive-field bounds for the current command.
  always_comb begin
    px_c      = NNW'(cmd_x_q) + pad;
    py_c      = NNW'(cmd_y_q) + pad;
    xs_c      = win_start(px_c, x_k, stride_log_x);
    xe_c      = win_end(px_c, x_in, pad, x_k, stride_log_x);
    ys_c      = win_start(py_c, y_k, stride_log_y);
    ye_c      = win_end(py_c, y_in, pad, y_k, stride_log_y);
    win_empty = (xs_c > xe_c) || (ys_c > ye_c);
  end

  // Beat addresses derived combinationally from the window registers.
  logic [NNW-1:0] xw, yw, wgt_c, vm_c;
  logic           last_c;

  // Weight/neuron address generation for the current window position.
  always_comb begin
    xw     = px_q - (xl_q << stride_log_x);
    yw     = py_q - (yl_q << stride_log_y);
    wgt_c  = yw * x_k + xw + zs_q * xk_yk;
    vm_c   = (yl_q - NNW'(y_start)) * x_out + (xl_q - NNW'(x_start));
    last_c = (xl_q == xl_end_q) && (yl_q == yl_end_q);
  end

  // Next-state logic: FIFO pops, window stepping and soma write generation.
  always_comb begin
    state_d    = state_q;
    cmd_x_d    = cmd_x_q;
    cmd_y_d    = cmd_y_q;
    cmd_z_d    = cmd_z_q;
    px_d       = px_q;
    py_d       = py_q;
    xl_d       = xl_q;
    yl_d       = yl_q;
    xl_start_d = xl_start_q;
    xl_end_d   = xl_end_q;
    yl_end_d   = yl_end_q;
    zs_d       = zs_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_type == TySpike) begin
            cmd_x_d = head_data[CW-1:0];
            cmd_y_d = head_data[2*CW-1:CW];
            cmd_z_d = head_data[SW-1:2*CW];
            state_d = StCalc;
          end else if (head_type == TyData) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = head_data;
            state_d = StInput;
          end
        end
      end
      StCalc: begin
        if (win_empty) begin
          state_d = StIdle;
        end else begin
          px_d       = px_c;
          py_d       = py_c;
          xl_d       = xs_c;
          yl_d       = ys_c;
          xl_start_d = xs_c;
          xl_end_d   = xe_c;
          yl_end_d   = ye_c;
          zs_d       = NNW'(cmd_z_q);
          state_d    = StSlide;
        end
      end
      StSlide: begin
        if (axon_sd_rdy) begin
          if (last_c) begin
            state_d = StIdle;
          end else if (xl_q == xl_end_q) begin
            xl_d = xl_start_q;
            yl_d = yl_q + 1'b1;
          end else begin
            xl_d = xl_q + 1'b1;
          end
        end
      end
      StInput: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_type == TyData || head_type == TyDataEnd) begin
            we_d    = 1'b1;
            waddr_d = waddr_q + 1'b1;
            wdata_d = head_data;
          end
          if (head_type == TyDataEnd) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_x_q    <= '0;
      cmd_y_q    <= '0;
      cmd_z_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      xl_q       <= '0;
      yl_q       <= '0;
      xl_start_q <= '0;
      xl_end_q   <= '0;
      yl_end_q   <= '0;
      zs_q       <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_x_q    <= cmd_x_d;
      cmd_y_q    <= cmd_y_d;
      cmd_z_q    <= cmd_z_d;
      px_q       <= px_d;
      py_q       <= py_d;
      xl_q       <= xl_d;
      yl_q       <= yl_d;
      xl_start_q <= xl_start_d;
      xl_end_q   <= xl_end_d;
      yl_end_q   <= yl_end_d;
      zs_q       <= zs_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // sd outputs are forced to zero outside SLIDE.
  assign axon_sd_vld      = (state_q == StSlide);
  assign axon_sd_last     = axon_sd_vld & last_c;
  assign axon_sd_vm_addr  = axon_sd_vld ? vm_c : '0;
  assign axon_sd_wgt_addr = axon_sd_vld ? wgt_c : '0;
  assign axon_soma_we     = we_q;
  assign axon_soma_waddr  = waddr_q;
  assign axon_soma_wdata  = wdata_q;
  assign fifo_cnt         = cnt_q;
  assign spk_in_rdy       = ~full;

endmodule
